// File: rtl/capture_sequencer_pkg.sv
// Shared definitions for the capture sequencer: FSM state encodings and transmitter flag layout.
package capture_sequencer_pkg;

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StPretrig  = 3'd1;
    localparam logic [2:0] StPosttrig = 3'd2;
    localparam logic [2:0] StStartTx  = 3'd3;
    localparam logic [2:0] StWaitTx   = 3'd4;

    localparam int unsigned TX_FLAGS_WIDTH = 16;
    localparam int unsigned FLAG_FULL      = 0;
    localparam int unsigned FLAG_TRIGGERED = 1;

endpackage

// File: rtl/capture_sequencer_if.sv
// Sample-RAM write port and DataTransmitter handshake between the sequencer and its consumers.
interface capture_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 8
);
    import capture_sequencer_pkg::*;

    logic                      mem_write_en;
    logic [ADDR_WIDTH-1:0]     mem_write_address;
    logic [DATA_WIDTH-1:0]     mem_write_data;
    logic                      tx_run;
    logic [TX_FLAGS_WIDTH-1:0] tx_flags;
    logic [ADDR_WIDTH-1:0]     tx_last_sample_address;
    logic                      tx_finished;

    modport master (
        output mem_write_en,
        output mem_write_address,
        output mem_write_data,
        output tx_run,
        output tx_flags,
        output tx_last_sample_address,
        input  tx_finished
    );

    modport slave (
        input  mem_write_en,
        input  mem_write_address,
        input  mem_write_data,
        input  tx_run,
        input  tx_flags,
        input  tx_last_sample_address,
        output tx_finished
    );

endinterface

// File: rtl/capture_address_counter.sv
// Circular sample-RAM write pointer with clear, increment and a sticky wrap (buffer full) flag.
module capture_address_counter #(
    parameter int unsigned WIDTH = 13
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             increment,
    output logic [WIDTH-1:0] value,
    output logic             wrapped
);

    logic [WIDTH-1:0] value_q;
    logic             wrapped_q;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            value_q   <= '0;
            wrapped_q <= 1'b0;
        end else if (increment) begin
            value_q <= value_q + WIDTH'(1);
            if (value_q == '1) begin
                wrapped_q <= 1'b1;
            end
        end
    end

    assign value   = value_q;
    assign wrapped = wrapped_q;

endmodule

// File: rtl/capture_sequencer.sv
// Sequences one logic-analyser capture: arm, circular sample storage, trigger, post-trigger
// countdown, then a single DataTransmitter run and completion handshake.
module capture_sequencer
    import capture_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  trigger,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic [ADDR_WIDTH-1:0] post_trigger_count,
    capture_sequencer_if.master   bus,
    output logic                  busy,
    output logic                  done
);

    logic [2:0]                state_q, state_d;
    logic [ADDR_WIDTH-1:0]     count_q;
    logic [ADDR_WIDTH-1:0]     remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0]     last_q, last_d;
    logic                      flags_live_q, flags_live_d;
    logic                      done_q;
    logic                      wr_en_q;
    logic [ADDR_WIDTH-1:0]     wr_addr_q;
    logic [DATA_WIDTH-1:0]     wr_data_q;
    logic [ADDR_WIDTH-1:0]     pointer;
    logic                      full;
    logic                      start;
    logic                      store;
    logic [TX_FLAGS_WIDTH-1:0] flags;

    assign start = (state_q == StIdle) && arm;
    assign store = ((state_q == StPretrig) || (state_q == StPosttrig)) && sample_valid;

    capture_address_counter #(
        .WIDTH(ADDR_WIDTH)
    ) u_address_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (start),
        .increment(store),
        .value    (pointer),
        .wrapped  (full)
    );

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        last_d       = last_q;
        flags_live_d = flags_live_q;
        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    state_d      = StPretrig;
                    last_d       = '0;
                    flags_live_d = 1'b0;
                end
            end
            StPretrig: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (sample_valid && trigger) begin
                    if (count_q == '0) begin
                        last_d       = pointer;
                        flags_live_d = 1'b1;
                        state_d      = StStartTx;
                    end else begin
                        remaining_d = count_q;
                        state_d     = StPosttrig;
                    end
                end
            end
            StPosttrig: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (sample_valid) begin
                    remaining_d = remaining_q - ADDR_WIDTH'(1);
                    if (remaining_q == ADDR_WIDTH'(1)) begin
                        last_d       = pointer;
                        flags_live_d = 1'b1;
                        state_d      = StStartTx;
                    end
                end
            end
            StStartTx: state_d = StWaitTx;
            StWaitTx: begin
                if (bus.tx_finished) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            count_q      <= '0;
            remaining_q  <= '0;
            last_q       <= '0;
            flags_live_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            last_q       <= last_d;
            flags_live_q <= flags_live_d;
            done_q       <= (state_q == StWaitTx) && bus.tx_finished;
            if (start) begin
                count_q <= post_trigger_count;
            end
        end
    end

    // Write path runs one cycle behind the sample strobe and completes even across an abort.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= store;
            if (store) begin
                wr_addr_q <= pointer;
                wr_data_q <= sample_data;
            end
        end
    end

    // Flags only become visible once the capture has committed to a transmit.
    always_comb begin
        flags                 = '0;
        flags[FLAG_TRIGGERED] = flags_live_q;
        flags[FLAG_FULL]      = flags_live_q & full;
    end

    assign bus.mem_write_en           = wr_en_q;
    assign bus.mem_write_address      = wr_addr_q;
    assign bus.mem_write_data         = wr_data_q;
    assign bus.tx_run                 = (state_q == StStartTx);
    assign bus.tx_flags               = flags;
    assign bus.tx_last_sample_address = last_q;
    assign busy                       = (state_q != StIdle);
    assign done                       = done_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Randomized self-checking bench: the k-th sample stored after arm must land at k mod depth.
module tb_capture_sequencer;

    localparam int AW    = 13;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clock;
    logic          reset;
    logic          arm;
    logic          abort;
    logic          trigger;
    logic          sample_valid;
    logic [DW-1:0] sample_data;
    logic [AW-1:0] post_trigger_count;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;
    int n_run    = 0;
    int n_done   = 0;

    logic [AW-1:0] got_addr[$];
    logic [DW-1:0] got_data[$];
    logic [DW-1:0] exp_data[$];

    capture_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    capture_sequencer #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .arm               (arm),
        .abort             (abort),
        .trigger           (trigger),
        .sample_valid      (sample_valid),
        .sample_data       (sample_data),
        .post_trigger_count(post_trigger_count),
        .bus               (bus),
        .busy              (busy),
        .done              (done)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.mem_write_en) begin
            got_addr.push_back(bus.mem_write_address);
            got_data.push_back(bus.mem_write_data);
        end
        if (bus.tx_run) n_run++;
        if (done) n_done++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        got_addr.delete();
        got_data.delete();
        exp_data.delete();
        n_run  = 0;
        n_done = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_done"}, 32'(done), 0);
        check_eq({tag, "_tx_run"}, 32'(bus.tx_run), 0);
        check_eq({tag, "_wr_en"}, 32'(bus.mem_write_en), 0);
        check_eq({tag, "_wr_addr"}, 32'(bus.mem_write_address), 0);
        check_eq({tag, "_wr_data"}, 32'(bus.mem_write_data), 0);
        check_eq({tag, "_flags"}, 32'(bus.tx_flags), 0);
        check_eq({tag, "_last"}, 32'(bus.tx_last_sample_address), 0);
    endtask

    task automatic check_writes(input string tag);
        int bad = 0;
        check_eq({tag, "_wr_count"}, 32'(got_addr.size()), 32'(exp_data.size()));
        for (int k = 0; k < exp_data.size() && k < got_addr.size(); k++) begin
            if (int'(got_addr[k]) != (k % DEPTH) || got_data[k] !== exp_data[k]) bad++;
        end
        check_eq({tag, "_wr_bad"}, 32'(bad), 0);
    endtask

    // Drive arm; a sample/trigger presented in the arm cycle must not be stored.
    task automatic do_arm(input int cnt);
        post_trigger_count = AW'(cnt);
        arm          = 1'b1;
        abort        = 1'($urandom);
        sample_valid = 1'($urandom);
        trigger      = 1'($urandom);
        sample_data  = DW'($urandom);
        tick();
        arm          = 1'b0;
        abort        = 1'b0;
        sample_valid = 1'b0;
        trigger      = 1'b0;
        check_eq("busy_after_arm", 32'(busy), 1);
    endtask

    task automatic push_sample(input logic trig);
        logic [DW-1:0] d;
        d = DW'($urandom);
        exp_data.push_back(d);
        sample_valid = 1'b1;
        sample_data  = d;
        trigger      = trig;
        tick();
    endtask

    task automatic run_capture(input int pre, input int cnt, input bit gaps, input bit trig_noise,
                               input bit poke, input bit rst_wait);
        int total;
        logic [31:0] exp_flags;
        clear_log();
        total     = pre + cnt + 1;
        exp_flags = 32'h2 | ((total >= DEPTH) ? 32'h1 : 32'h0);
        do_arm(cnt);
        if (trig_noise) begin
            trigger = 1'b1;
            repeat (3) tick();
            trigger = 1'b0;
            check_eq("pretrig_hold_busy", 32'(busy), 1);
            check_eq("pretrig_no_run", 32'(n_run), 0);
        end
        for (int i = 0; i < total; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    sample_valid = 1'b0;
                    trigger      = 1'($urandom);
                    tick();
                end
            end
            push_sample((i == pre) ? 1'b1 : ((i > pre) ? 1'($urandom) : 1'b0));
        end
        sample_valid = 1'b0;
        trigger      = 1'b0;
        abort        = poke;
        tick();
        abort = 1'b0;
        arm   = poke;
        tick();
        arm = 1'b0;
        repeat (3) begin
            sample_valid = 1'($urandom);
            sample_data  = DW'($urandom);
            trigger      = 1'($urandom);
            tick();
        end
        sample_valid = 1'b0;
        trigger      = 1'b0;
        check_eq("tx_run_once", 32'(n_run), 1);
        check_eq("busy_wait_tx", 32'(busy), 1);
        check_eq("last_addr", 32'(bus.tx_last_sample_address), 32'((pre + cnt) % DEPTH));
        check_eq("flags", 32'(bus.tx_flags), exp_flags);
        check_writes("cap");
        if (rst_wait) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            check_idle_outputs("mid_reset");
        end else begin
            bus.tx_finished = 1'b1;
            repeat ($urandom_range(1, 2)) tick();
            bus.tx_finished = 1'b0;
            tick();
            check_eq("done_once", 32'(n_done), 1);
            check_eq("busy_after_done", 32'(busy), 0);
        end
    endtask

    task automatic run_abort(input int pre);
        clear_log();
        do_arm(6);
        for (int i = 0; i < pre + 4; i++) push_sample(i == pre);
        sample_valid = 1'b0;
        trigger      = 1'b0;
        abort        = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_busy", 32'(busy), 0);
        repeat (3) tick();
        check_eq("abort_no_run", 32'(n_run), 0);
        check_eq("abort_no_done", 32'(n_done), 0);
        check_eq("abort_flags", 32'(bus.tx_flags), 0);
        check_writes("abort");
    endtask

    initial begin
        clock              = 1'b0;
        reset              = 1'b1;
        arm                = 1'b0;
        abort              = 1'b0;
        trigger            = 1'b0;
        sample_valid       = 1'b0;
        sample_data        = '0;
        post_trigger_count = '0;
        bus.tx_finished    = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        reset = 1'b0;

        // Without arm nothing may be written or started.
        repeat (4) begin
            abort        = 1'($urandom);
            sample_valid = 1'($urandom);
            trigger      = 1'($urandom);
            tick();
        end
        abort        = 1'b0;
        sample_valid = 1'b0;
        trigger      = 1'b0;
        check_eq("idle_busy", 32'(busy), 0);
        check_eq("idle_no_write", 32'(got_addr.size()), 0);

        run_capture(10, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        run_capture(0, 3, 1'b1, 1'b1, 1'b0, 1'b0);
        run_capture(8200, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_abort(7);
        run_capture(4, 2, 1'b1, 1'b0, 1'b0, 1'b1);
        run_capture(3, 4, 1'b0, 1'b0, 1'b1, 1'b0);
        run_capture(100, 8150, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 16; r++) begin
            run_capture(int'($urandom_range(0, 30)), int'($urandom_range(0, 30)),
                        1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
